adc_ddr_wr_scheduler: RTL
=========================

Name: adc_ddr_wr_scheduler

Overview:
Sequences the AXI burst-write engine that moves ADC FIFO data to DDR. Each acquisition frame request is mapped onto one slot of a DDR ring of N frame buffers. For each frame the block issues a single start command with a computed address and length, waits for completion, and then updates buffer occupancy, counters and an interrupt pulse for the PS. Software returns slots with an acknowledge; frames that arrive while the ring is full are dropped and counted.

Parameters:
MAX_BUFS, 16, maximum ring depth; sets the width of the index and fill counters (4 bits for idx, 5 bits for fill).
TIMEOUT_CYCLES, 32'd50_000_000, ACLK cycles allowed between WR_START and WR_DONE before the frame is aborted.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
CTRL_EN  in  1  level; 1 = scheduler armed
CTRL_CONT  in  1  1 = continuous capture; 0 = single frame, then return to IDLE
CFG_BASE_ADRS  in  32  DDR address of buffer 0; 8-byte aligned
CFG_STRIDE  in  32  byte distance between buffers
CFG_FRAME_LEN  in  32  bytes per frame; nonzero multiple of 8
CFG_BUF_NUM  in  5  ring depth 1..MAX_BUFS; 0 is treated as 1, values >MAX_BUFS are clamped
FRAME_REQ  in  1  one-cycle pulse from acquisition logic: a frame's data is entering the write FIFO
BUF_ACK  in  1  one-cycle pulse from software: the oldest filled buffer is released
WR_START  out  1  one-cycle start command to the write engine
WR_ADRS  out  32  frame start address; held stable from WR_START until WR_DONE
WR_LEN  out  32  frame length in bytes
WR_READY  in  1  write engine idle
WR_DONE  in  1  one-cycle write-complete pulse
MASTER_RST  out  1  one-cycle abort pulse to the write engine
IRQ  out  1  one-cycle pulse per completed frame
LAST_IDX  out  4  index of the most recently completed buffer
FILL  out  5  buffers written but not yet acknowledged
FRAME_CNT  out  32  completed frames (wraps)
DROP_CNT  out  16  dropped frame requests (saturates at 16'hFFFF)
OVERRUN  out  1  sticky drop flag
TIMEOUT_ERR  out  1  sticky timeout flag
BUSY  out  1  1 whenever state != IDLE

Behaviour:
- Reset: all outputs and internal registers are 0; state = IDLE.
- Configuration is latched on the IDLE->ARM transition and ignored afterwards. cur_adrs = base; wr_idx = 0; fill = 0; OVERRUN, TIMEOUT_ERR, FRAME_CNT and DROP_CNT are cleared.
- req_pending is a single-deep latch set by FRAME_REQ and cleared when a start is issued or the request is dropped.
  - If FRAME_REQ arrives while req_pending = 1, or while state is BUSY, DONE or ERR, the request is dropped: DROP_CNT++ and OVERRUN = 1.
- IDLE: CTRL_EN = 1 -> ARM.
- ARM, evaluated in priority order:
  - CTRL_EN = 0 -> IDLE.
  - req_pending and fill == buf_num -> drop; remain in ARM.
  - req_pending and fill < buf_num and WR_READY -> WR_START = 1 for one cycle; WR_ADRS = cur_adrs; WR_LEN = frame_len; timer = 0; go to BUSY.
  - req_pending with WR_READY = 0 -> wait in ARM.
- BUSY:
  - WR_DONE -> DONE. WR_DONE outside BUSY is ignored.
  - Otherwise timer++; when timer == TIMEOUT_CYCLES-1, MASTER_RST = 1 for one cycle, TIMEOUT_ERR = 1, go to ERR.
  - CTRL_EN falling during BUSY does not abort the frame.
- DONE (one cycle):
  - IRQ = 1; FRAME_CNT++; LAST_IDX = wr_idx; fill++.
  - If wr_idx == buf_num-1: wr_idx = 0 and cur_adrs = base. Otherwise wr_idx++ and cur_adrs += stride (mod 2^32).
  - Next state is ARM if CTRL_CONT = 1 and CTRL_EN = 1; otherwise IDLE.
- ERR: held until CTRL_EN = 0, then IDLE. A later re-arm clears TIMEOUT_ERR.
- BUF_ACK:
  - fill-- when fill > 0; BUF_ACK with fill == 0 is ignored.
  - BUF_ACK coinciding with the DONE increment leaves fill unchanged.
  - Acknowledges are accepted in every state except IDLE.
- A fill-full check always reflects BUF_ACK from the previous cycle.
- Latency: FRAME_REQ in cycle t with the ring free and WR_READY = 1 gives WR_START in cycle t+2 (t+1 latch, t+2 issue).

Test Plan:
- Base 0x1000_0000, stride 0x10_0000, len 0x4000, num 4, cont. Six FRAME_REQs, each WR_DONE returned 100 cycles after WR_START, BUF_ACK after every IRQ -> WR_ADRS sequence 0x1000_0000, 0x1010_0000, 0x1020_0000, 0x1030_0000, 0x1000_0000, 0x1010_0000; FRAME_CNT = 6; LAST_IDX = 1.
- Same setup with no BUF_ACK and 6 requests -> 4 starts, FILL = 4, DROP_CNT = 2, OVERRUN = 1. One BUF_ACK then one FRAME_REQ -> start at 0x1000_0000.
- WR_DONE withheld with TIMEOUT_CYCLES = 1000 -> MASTER_RST pulses exactly 1000 cycles after WR_START, TIMEOUT_ERR = 1, no IRQ. CTRL_EN toggle then re-arm -> TIMEOUT_ERR cleared.
- CTRL_CONT = 0, two FRAME_REQs 10 cycles apart -> one WR_START, second request counted in DROP_CNT, state returns to IDLE, BUSY = 0.
- BUF_ACK in the same cycle as DONE with FILL = 2 -> FILL stays 2. BUF_ACK with FILL = 0 -> FILL stays 0.
- ARESETN asserted mid-BUSY -> all outputs are 0 on the next edge. After release, the new CFG_BASE_ADRS is used for the first start.

Source files
------------

// File: rtl/adc_ddr_wr_scheduler.sv
// adc_ddr_wr_scheduler: maps acquisition frame requests onto a ring of DDR frame
// buffers, issues one start command per frame to the AXI burst-write engine, supervises
// completion with a timeout, and tracks ring occupancy, counters and a per-frame IRQ.
module adc_ddr_wr_scheduler #(
    parameter int unsigned MAX_BUFS       = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        CTRL_EN,
    input  logic        CTRL_CONT,
    input  logic [31:0] CFG_BASE_ADRS,
    input  logic [31:0] CFG_STRIDE,
    input  logic [31:0] CFG_FRAME_LEN,
    input  logic [4:0]  CFG_BUF_NUM,
    input  logic        FRAME_REQ,
    input  logic        BUF_ACK,
    output logic        WR_START,
    output logic [31:0] WR_ADRS,
    output logic [31:0] WR_LEN,
    input  logic        WR_READY,
    input  logic        WR_DONE,
    output logic        MASTER_RST,
    output logic        IRQ,
    output logic [3:0]  LAST_IDX,
    output logic [4:0]  FILL,
    output logic [31:0] FRAME_CNT,
    output logic [15:0] DROP_CNT,
    output logic        OVERRUN,
    output logic        TIMEOUT_ERR,
    output logic        BUSY
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StArm  = 3'd1;
    localparam logic [2:0] StBusy = 3'd2;
    localparam logic [2:0] StDone = 3'd3;
    localparam logic [2:0] StErr  = 3'd4;

    localparam logic [4:0]  MaxBufs     = 5'(MAX_BUFS);
    localparam logic [31:0] TimeoutLast = TIMEOUT_CYCLES - 32'd1;

    logic [2:0]  state_q, state_d;
    logic        req_pending_q, req_pending_d;
    logic [31:0] base_q, base_d;
    logic [31:0] stride_q, stride_d;
    logic [31:0] len_q, len_d;
    logic [4:0]  buf_num_q, buf_num_d;
    logic [31:0] cur_adrs_q, cur_adrs_d;
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic [4:0]  fill_q, fill_d;
    logic [31:0] timer_q, timer_d;
    logic        wr_start_q, wr_start_d;
    logic [31:0] wr_adrs_q, wr_adrs_d;
    logic [31:0] wr_len_q, wr_len_d;
    logic        master_rst_q, master_rst_d;
    logic        irq_q, irq_d;
    logic [3:0]  last_idx_q, last_idx_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;

    logic [4:0]  cfg_buf_num;
    logic        start_issue, drop_pend, drop_new, leave_arm;
    logic        done_inc, ack_dec;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    // Clamp the requested ring depth into 1..MAX_BUFS
    always_comb begin
        if (CFG_BUF_NUM == 5'd0) begin
            cfg_buf_num = 5'd1;
        end else if (CFG_BUF_NUM > MaxBufs) begin
            cfg_buf_num = MaxBufs;
        end else begin
            cfg_buf_num = CFG_BUF_NUM;
        end
    end

    // Next-state: sequencing FSM, request latch, occupancy and counters
    always_comb begin
        state_d       = state_q;
        req_pending_d = req_pending_q;
        base_d        = base_q;
        stride_d      = stride_q;
        len_d         = len_q;
        buf_num_d     = buf_num_q;
        cur_adrs_d    = cur_adrs_q;
        wr_idx_d      = wr_idx_q;
        fill_d        = fill_q;
        timer_d       = timer_q;
        wr_start_d    = 1'b0;
        wr_adrs_d     = wr_adrs_q;
        wr_len_d      = wr_len_q;
        master_rst_d  = 1'b0;
        irq_d         = 1'b0;
        last_idx_d    = last_idx_q;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        start_issue   = 1'b0;
        drop_pend     = 1'b0;
        drop_new      = 1'b0;
        leave_arm     = 1'b0;
        done_inc      = (state_q == StDone);
        ack_dec       = BUF_ACK && (state_q != StIdle) && (fill_q != 5'd0);
        drop_inc      = 2'd0;
        drop_sum      = 17'd0;

        case (state_q)
            StIdle: begin
                if (CTRL_EN) begin
                    // Snapshot configuration; it is ignored until the next arm
                    state_d       = StArm;
                    base_d        = CFG_BASE_ADRS;
                    stride_d      = CFG_STRIDE;
                    len_d         = CFG_FRAME_LEN;
                    buf_num_d     = cfg_buf_num;
                    cur_adrs_d    = CFG_BASE_ADRS;
                    wr_idx_d      = 4'd0;
                    fill_d        = 5'd0;
                    overrun_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    frame_cnt_d   = 32'd0;
                    drop_cnt_d    = 16'd0;
                end
            end
            StArm: begin
                if (!CTRL_EN) begin
                    state_d   = StIdle;
                    leave_arm = 1'b1;
                end else if (req_pending_q) begin
                    if (fill_q == buf_num_q) begin
                        drop_pend = 1'b1;
                    end else if (WR_READY) begin
                        start_issue = 1'b1;
                        wr_start_d  = 1'b1;
                        wr_adrs_d   = cur_adrs_q;
                        wr_len_d    = len_q;
                        timer_d     = 32'd0;
                        state_d     = StBusy;
                    end
                end
            end
            StBusy: begin
                // CTRL_EN is deliberately not looked at: a started frame always finishes
                if (WR_DONE) begin
                    state_d = StDone;
                end else if (timer_q == TimeoutLast) begin
                    master_rst_d  = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = StErr;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StDone: begin
                irq_d       = 1'b1;
                frame_cnt_d = frame_cnt_q + 32'd1;
                last_idx_d  = wr_idx_q;
                if ({1'b0, wr_idx_q} == buf_num_q - 5'd1) begin
                    wr_idx_d   = 4'd0;
                    cur_adrs_d = base_q;
                end else begin
                    wr_idx_d   = wr_idx_q + 4'd1;
                    cur_adrs_d = cur_adrs_q + stride_q;
                end
                state_d = (CTRL_CONT && CTRL_EN) ? StArm : StIdle;
            end
            StErr: begin
                if (!CTRL_EN) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Single-deep request latch; only an idle ARM state with no pending request accepts
        req_pending_d = req_pending_q & ~(start_issue | drop_pend | leave_arm);
        if (FRAME_REQ && (state_q != StIdle)) begin
            if (req_pending_q || (state_q != StArm)) begin
                drop_new = 1'b1;
            end else if (!leave_arm) begin
                req_pending_d = 1'b1;
            end
        end

        // A DONE increment and an acknowledge in the same cycle cancel out
        if (state_q != StIdle) begin
            fill_d = fill_q + {4'd0, done_inc} - {4'd0, ack_dec};
        end

        // Up to two drops per cycle: the pending request and a fresh one behind it
        drop_inc = {1'b0, drop_new} + {1'b0, drop_pend};
        drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
        if (drop_inc != 2'd0) begin
            overrun_d  = 1'b1;
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= StIdle;
            req_pending_q <= 1'b0;
            base_q        <= 32'd0;
            stride_q      <= 32'd0;
            len_q         <= 32'd0;
            buf_num_q     <= 5'd0;
            cur_adrs_q    <= 32'd0;
            wr_idx_q      <= 4'd0;
            fill_q        <= 5'd0;
            timer_q       <= 32'd0;
            wr_start_q    <= 1'b0;
            wr_adrs_q     <= 32'd0;
            wr_len_q      <= 32'd0;
            master_rst_q  <= 1'b0;
            irq_q         <= 1'b0;
            last_idx_q    <= 4'd0;
            frame_cnt_q   <= 32'd0;
            drop_cnt_q    <= 16'd0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pending_q <= req_pending_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            len_q         <= len_d;
            buf_num_q     <= buf_num_d;
            cur_adrs_q    <= cur_adrs_d;
            wr_idx_q      <= wr_idx_d;
            fill_q        <= fill_d;
            timer_q       <= timer_d;
            wr_start_q    <= wr_start_d;
            wr_adrs_q     <= wr_adrs_d;
            wr_len_q      <= wr_len_d;
            master_rst_q  <= master_rst_d;
            irq_q         <= irq_d;
            last_idx_q    <= last_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        WR_START    = wr_start_q;
        WR_ADRS     = wr_adrs_q;
        WR_LEN      = wr_len_q;
        MASTER_RST  = master_rst_q;
        IRQ         = irq_q;
        LAST_IDX    = last_idx_q;
        FILL        = fill_q;
        FRAME_CNT   = frame_cnt_q;
        DROP_CNT    = drop_cnt_q;
        OVERRUN     = overrun_q;
        TIMEOUT_ERR = timeout_err_q;
        BUSY        = (state_q != StIdle);
    end

endmodule
